// File: rtl/vc_store_array.sv
// Fully associative victim-cache store: registered tag lookup, fill with
// match/invalid/PLRU way selection, dirty-victim eviction and invalidation.
module vc_store_array #(
  parameter int unsigned S_LINE    = 256,
  parameter int unsigned TAG_WIDTH = 27,
  parameter int unsigned NUM_WAYS  = 8,
  parameter int unsigned WAY_BITS  = $clog2(NUM_WAYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lookup_valid,
  input  logic [TAG_WIDTH-1:0] lookup_tag,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [WAY_BITS-1:0]  resp_way,
  output logic                 resp_dirty,
  output logic [S_LINE-1:0]    resp_rdata,
  input  logic                 fill_valid,
  input  logic [TAG_WIDTH-1:0] fill_tag,
  input  logic [S_LINE-1:0]    fill_data,
  input  logic                 fill_dirty,
  input  logic                 inval_valid,
  input  logic [WAY_BITS-1:0]  inval_way,
  output logic                 evict_valid,
  output logic [TAG_WIDTH-1:0] evict_tag,
  output logic [S_LINE-1:0]    evict_data,
  output logic [NUM_WAYS-1:0]  valid_vec,
  output logic [NUM_WAYS-1:0]  dirty_vec,
  output logic [WAY_BITS:0]    occupancy
);

  logic [TAG_WIDTH-1:0] tag_q  [NUM_WAYS];
  logic [S_LINE-1:0]    data_q [NUM_WAYS];
  logic [NUM_WAYS-1:0]  valid_q, valid_d, dirty_q, dirty_d;
  logic [NUM_WAYS-2:0]  plru_q, plru_d;
  logic [WAY_BITS:0]    occ_q;

  logic                 resp_valid_q, resp_hit_q, resp_dirty_q;
  logic [WAY_BITS-1:0]  resp_way_q;
  logic [S_LINE-1:0]    resp_rdata_q;
  logic                 evict_valid_q, evict_d;
  logic [TAG_WIDTH-1:0] evict_tag_q;
  logic [S_LINE-1:0]    evict_data_q;

  logic                 lk_hit, fl_match, fl_free, lk_take;
  logic [WAY_BITS-1:0]  lk_way, fl_match_way, fl_free_way, victim_way, fill_way;

  // Heap-ordered tree; way bit l selects the branch at tree level l (bit 0 at the root).
  function automatic logic [WAY_BITS-1:0] plru_victim(input logic [NUM_WAYS-2:0] tree);
    int unsigned node;
    logic [WAY_BITS-1:0] way;
    node = 0;
    way  = '0;
    for (int unsigned l = 0; l < WAY_BITS; l++) begin
      way[l] = tree[node];
      node   = 2 * node + (tree[node] ? 2 : 1);
    end
    return way;
  endfunction

  function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] tree,
                                                     input logic [WAY_BITS-1:0] way);
    int unsigned node;
    logic [NUM_WAYS-2:0] t;
    node = 0;
    t    = tree;
    for (int unsigned l = 0; l < WAY_BITS; l++) begin
      t[node] = ~way[l];
      node    = 2 * node + (way[l] ? 2 : 1);
    end
    return t;
  endfunction

  function automatic logic [WAY_BITS:0] popcount(input logic [NUM_WAYS-1:0] v);
    logic [WAY_BITS:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) c = c + {{WAY_BITS{1'b0}}, v[i]};
    return c;
  endfunction

  always_comb begin
    lk_hit       = 1'b0;
    lk_way       = '0;
    fl_match     = 1'b0;
    fl_match_way = '0;
    fl_free      = 1'b0;
    fl_free_way  = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[w] && tag_q[w] == lookup_tag) begin
        lk_hit = 1'b1;
        lk_way = w[WAY_BITS-1:0];
      end
      if (valid_q[w] && tag_q[w] == fill_tag) begin
        fl_match     = 1'b1;
        fl_match_way = w[WAY_BITS-1:0];
      end
      if (!valid_q[w] && !fl_free) begin
        fl_free     = 1'b1;
        fl_free_way = w[WAY_BITS-1:0];
      end
    end
  end

  assign victim_way = plru_victim(plru_q);
  assign fill_way   = fl_match ? fl_match_way : (fl_free ? fl_free_way : victim_way);
  assign lk_take    = lookup_valid & lk_hit;
  assign evict_d    = fill_valid & ~fl_match & ~fl_free & dirty_q[victim_way];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    plru_d  = plru_q;
    if (lk_take) plru_d = plru_touch(plru_d, lk_way);
    if (inval_valid) begin
      valid_d[inval_way] = 1'b0;
      dirty_d[inval_way] = 1'b0;
    end
    // Fill is applied after inval and lookup so it wins both conflicts.
    if (fill_valid) begin
      valid_d[fill_way] = 1'b1;
      dirty_d[fill_way] = fill_dirty;
      plru_d            = plru_touch(plru_d, fill_way);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      dirty_q       <= '0;
      plru_q        <= '0;
      occ_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_way_q    <= '0;
      resp_dirty_q  <= 1'b0;
      resp_rdata_q  <= '0;
      evict_valid_q <= 1'b0;
      evict_tag_q   <= '0;
      evict_data_q  <= '0;
    end else begin
      valid_q       <= valid_d;
      dirty_q       <= dirty_d;
      plru_q        <= plru_d;
      occ_q         <= popcount(valid_d);
      resp_valid_q  <= lookup_valid;
      resp_hit_q    <= lk_take;
      resp_way_q    <= lk_take ? lk_way : '0;
      resp_dirty_q  <= lk_take & dirty_q[lk_way];
      resp_rdata_q  <= lk_take ? data_q[lk_way] : '0;
      evict_valid_q <= evict_d;
      if (evict_d) begin
        evict_tag_q  <= tag_q[victim_way];
        evict_data_q <= data_q[victim_way];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_valid) begin
      tag_q[fill_way]  <= fill_tag;
      data_q[fill_way] <= fill_data;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_hit_q;
  assign resp_way    = resp_way_q;
  assign resp_dirty  = resp_dirty_q;
  assign resp_rdata  = resp_rdata_q;
  assign evict_valid = evict_valid_q;
  assign evict_tag   = evict_tag_q;
  assign evict_data  = evict_data_q;
  assign valid_vec   = valid_q;
  assign dirty_vec   = dirty_q;
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_vc_store_array.sv
// Bench for vc_store_array: directed scenarios plus random traffic checked
// every cycle against an array/queue-level model of the store.
module tb_vc_store_array;
  localparam int SL = 256;
  localparam int TW = 27;
  localparam int NW = 8;
  localparam int WB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          lookup_valid, fill_valid, fill_dirty, inval_valid;
  logic [TW-1:0] lookup_tag, fill_tag;
  logic [SL-1:0] fill_data;
  logic [WB-1:0] inval_way;
  logic          resp_valid, resp_hit, resp_dirty, evict_valid;
  logic [WB-1:0] resp_way;
  logic [SL-1:0] resp_rdata, evict_data;
  logic [TW-1:0] evict_tag;
  logic [NW-1:0] valid_vec, dirty_vec;
  logic [WB:0]   occupancy;

  vc_store_array #(.S_LINE(SL), .TAG_WIDTH(TW), .NUM_WAYS(NW)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_tag(lookup_tag),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .resp_dirty(resp_dirty), .resp_rdata(resp_rdata),
    .fill_valid(fill_valid), .fill_tag(fill_tag), .fill_data(fill_data),
    .fill_dirty(fill_dirty), .inval_valid(inval_valid), .inval_way(inval_way),
    .evict_valid(evict_valid), .evict_tag(evict_tag), .evict_data(evict_data),
    .valid_vec(valid_vec), .dirty_vec(dirty_vec), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [SL-1:0] act, input logic [SL-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference store
  logic [TW-1:0] m_tag   [NW];
  logic [SL-1:0] m_data  [NW];
  bit            m_valid [NW];
  bit            m_dirty [NW];
  bit            m_plru  [NW-1];

  bit            exp_resp_valid, exp_resp_hit, exp_resp_dirty, exp_evict_valid;
  int            exp_resp_way;
  logic [SL-1:0] exp_resp_rdata, exp_evict_data;
  logic [TW-1:0] exp_evict_tag;

  function automatic logic [SL-1:0] rep(input int t);
    logic [31:0] w;
    w = t;
    return {(SL/32){w}};
  endfunction

  function automatic logic [NW-1:0] vec_of(input bit which);
    logic [NW-1:0] v;
    for (int i = 0; i < NW; i++) v[i] = which ? m_dirty[i] : m_valid[i];
    return v;
  endfunction

  function automatic int count_valid();
    int c = 0;
    for (int i = 0; i < NW; i++) c += m_valid[i];
    return c;
  endfunction

  task automatic m_touch(input int w);
    int node = 0;
    for (int l = 0; l < WB; l++) begin
      int d = (w >> l) & 1;
      m_plru[node] = (d == 0);
      node = 2 * node + 1 + d;
    end
  endtask

  function automatic int m_victim();
    int node = 0;
    int w = 0;
    for (int l = 0; l < WB; l++) begin
      int d = m_plru[node];
      w |= d << l;
      node = 2 * node + 1 + d;
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    for (int i = 0; i < NW - 1; i++) m_plru[i] = 0;
    exp_resp_valid  = 0;
    exp_resp_hit    = 0;
    exp_resp_dirty  = 0;
    exp_resp_way    = 0;
    exp_resp_rdata  = '0;
    exp_evict_valid = 0;
    exp_evict_tag   = '0;
    exp_evict_data  = '0;
  endtask

  task automatic model_step();
    int hway, fway;
    bit hit, matched, freed;
    if (rst) begin
      model_reset();
      return;
    end
    hit = 0;
    hway = 0;
    for (int w = 0; w < NW; w++)
      if (m_valid[w] && m_tag[w] == lookup_tag) begin
        hit = 1;
        hway = w;
      end
    hit            = hit && lookup_valid;
    exp_resp_valid = lookup_valid;
    exp_resp_hit   = hit;
    exp_resp_way   = hit ? hway : 0;
    exp_resp_dirty = hit && m_dirty[hway];
    exp_resp_rdata = hit ? m_data[hway] : '0;
    exp_evict_valid = 0;
    fway = 0;
    if (fill_valid) begin
      matched = 0;
      freed = 0;
      for (int w = 0; w < NW; w++)
        if (m_valid[w] && m_tag[w] == fill_tag) begin
          matched = 1;
          fway = w;
        end
      if (!matched)
        for (int w = NW - 1; w >= 0; w--)
          if (!m_valid[w]) begin
            freed = 1;
            fway = w;
          end
      if (!matched && !freed) begin
        fway = m_victim();
        if (m_dirty[fway]) begin
          exp_evict_valid = 1;
          exp_evict_tag   = m_tag[fway];
          exp_evict_data  = m_data[fway];
        end
      end
    end
    if (hit) m_touch(hway);
    if (inval_valid) begin
      m_valid[inval_way] = 0;
      m_dirty[inval_way] = 0;
    end
    if (fill_valid) begin
      m_tag[fway]   = fill_tag;
      m_data[fway]  = fill_data;
      m_valid[fway] = 1;
      m_dirty[fway] = fill_dirty;
      m_touch(fway);
    end
  endtask

  // Per-cycle compare, 1 time unit after the active edge
  always @(posedge clk) begin
    #1;
    if (check_en) begin
      chk("resp_valid", resp_valid, exp_resp_valid);
      if (exp_resp_valid) begin
        chk("resp_hit", resp_hit, exp_resp_hit);
        chk("resp_way", resp_way, exp_resp_way);
        chk("resp_dirty", resp_dirty, exp_resp_dirty);
        chk("resp_rdata", resp_rdata, exp_resp_rdata);
      end
      chk("evict_valid", evict_valid, exp_evict_valid);
      if (exp_evict_valid) begin
        chk("evict_tag", evict_tag, exp_evict_tag);
        chk("evict_data", evict_data, exp_evict_data);
      end
      chk("valid_vec", valid_vec, vec_of(0));
      chk("dirty_vec", dirty_vec, vec_of(1));
      chk("occupancy", occupancy, count_valid());
    end
  end

  task automatic drive(input bit lv, input int lt, input bit fv, input int ft,
                       input logic [SL-1:0] fd, input bit fdy, input bit iv, input int iw);
    lookup_valid = lv;
    lookup_tag   = lt[TW-1:0];
    fill_valid   = fv;
    fill_tag     = ft[TW-1:0];
    fill_data    = fd;
    fill_dirty   = fdy;
    inval_valid  = iv;
    inval_way    = iw[WB-1:0];
    model_step();
    @(negedge clk);
  endtask

  task automatic lookup(input int t);
    drive(1, t, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic fill(input int t, input logic [SL-1:0] d, input bit dy);
    drive(0, 0, 1, t, d, dy, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    lookup_valid = 0; fill_valid = 0; inval_valid = 0; fill_dirty = 0;
    lookup_tag = '0; fill_tag = '0; fill_data = '0; inval_way = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    chk("rst_occupancy", occupancy, 0);
    chk("rst_valid_vec", valid_vec, 0);
    rst = 1'b0;

    lookup(32'h1);
    chk("lk1_valid", resp_valid, 1);
    chk("lk1_hit", resp_hit, 0);
    chk("lk1_rdata", resp_rdata, 0);
    chk("lk1_occ", occupancy, 0);

    for (int t = 'h10; t <= 'h17; t++) begin
      fill(t, rep(t), t[0]);
      chk("fill_valid_vec", valid_vec, (1 << (t - 'h10 + 1)) - 1);
      chk("fill_no_evict", evict_valid, 0);
    end
    chk("full_occ", occupancy, 8);
    chk("full_dirty", dirty_vec, 8'hAA);

    lookup('h13);
    chk("lk13_hit", resp_hit, 1);
    chk("lk13_way", resp_way, 3);
    chk("lk13_dirty", resp_dirty, 1);
    chk("lk13_rdata", resp_rdata, rep('h13));
    lookup('h99);
    chk("lk99_hit", resp_hit, 0);

    for (int w = 0; w < 7; w++) lookup('h10 + w);
    fill('h20, rep('h20), 0);
    chk("ev20_valid", evict_valid, 1);
    chk("ev20_tag", evict_tag, 'h17);
    chk("ev20_data", evict_data, rep('h17));
    lookup('h17);
    chk("lk17_miss", resp_hit, 0);
    lookup('h20);
    chk("lk20_hit", resp_hit, 1);
    chk("lk20_way", resp_way, 7);

    fill('h12, rep('h5a5a), 1);
    chk("ow12_evict", evict_valid, 0);
    chk("ow12_dirty", dirty_vec, 8'h2E);
    chk("ow12_occ", occupancy, 8);
    lookup('h12);
    chk("lk12_way", resp_way, 2);
    chk("lk12_rdata", resp_rdata, rep('h5a5a));

    drive(0, 0, 1, 'h30, rep('h30), 0, 1, 5);
    chk("inv5_bit5", valid_vec[5], 0);
    chk("inv5_occ", occupancy, 7);
    chk("fill30_evict_tag", evict_tag, 'h11);
    lookup('h30);
    chk("lk30_way", resp_way, 1);

    lookup_valid = 1;
    lookup_tag = 'h30;
    rst = 1'b1;
    #1;
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_occ", occupancy, 0);
    chk("midrst_valid_vec", valid_vec, 0);
    model_reset();
    repeat (2) drive(1, 'h30, 0, 0, '0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      drive($urandom_range(0, 1), $urandom_range(0, 23),
            $urandom_range(0, 2) != 0, $urandom_range(0, 15),
            {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, NW - 1));
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, '0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vc_store_array.md
# vc_store_array

Parametrised victim-cache storage array: a fully associative store of NUM_WAYS lines with tag, valid and dirty per way and a tree-PLRU replacement state. It sits between the L1 miss path and the victim-cache controller. It performs registered tag lookups, allocates evicted L1 lines into an invalid or PLRU way, and returns the displaced line for writeback. It replaces the fixed 8-entry store with a single-output mux by adding real hit-way selection, allocation and eviction, and generalises the width and depth.

## Interface
- S_LINE, 256: line width in bits.
- TAG_WIDTH, 27: tag width in bits.
- NUM_WAYS, 8: entry count; power of two, 2 to 32.
- WAY_BITS, $clog2(NUM_WAYS): way index width (derived).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- lookup_valid  in  1  lookup request this cycle.
- lookup_tag  in  TAG_WIDTH  tag to search.
- resp_valid  out  1  lookup response valid (registered).
- resp_hit  out  1  lookup hit.
- resp_way  out  WAY_BITS  hitting way; 0 on miss.
- resp_dirty  out  1  dirty bit of the hitting way; 0 on miss.
- resp_rdata  out  S_LINE  data of the hitting way; all zero on miss.
- fill_valid  in  1  allocate or overwrite a line.
- fill_tag  in  TAG_WIDTH  tag of the incoming line.
- fill_data  in  S_LINE  incoming line.
- fill_dirty  in  1  dirty bit of the incoming line.
- inval_valid  in  1  invalidate one way (line swapped back to L1).
- inval_way  in  WAY_BITS  way to invalidate.
- evict_valid  out  1  a valid dirty line was displaced by the previous fill.
- evict_tag  out  TAG_WIDTH  displaced tag.
- evict_data  out  S_LINE  displaced data.
- valid_vec  out  NUM_WAYS  per-way valid bits.
- dirty_vec  out  NUM_WAYS  per-way dirty bits.
- occupancy  out  WAY_BITS+1  count of valid ways.

## Operation
- Reset clears all valid, dirty and PLRU bits, all response and evict registers, and occupancy to 0. Tag and data arrays are not reset.
- Lookup: compare lookup_tag against every valid way. At most one way can match, because fill guarantees tag uniqueness.
  - Hit: capture the way, dirty bit and data into the response registers, and touch the PLRU for that way.
  - Miss: resp_hit=0, resp_way=0, resp_dirty=0, resp_rdata=0.
  - An invalid way never hits, whatever its stale tag.
- Fill: the target way is chosen in this order:
  1. the valid way whose tag equals fill_tag (overwrite in place, no eviction);
  2. otherwise the lowest-index invalid way;
  3. otherwise the PLRU victim.
- Fill write: write tag and data, set valid=1 and dirty=fill_dirty, and touch the PLRU for the target way.
- Eviction: evict_valid=1 for exactly one cycle only when case 3 is taken and the victim is dirty. evict_tag and evict_data carry the victim's pre-write contents. When evict_valid=0, the evict registers hold their last value.
- Tree PLRU: NUM_WAYS-1 node bits. Victim search starts at the root: bit 0 goes left, bit 1 goes right. A touch of way w sets every node on w's path to point away from w.
- Invalidate: clear valid and dirty of inval_way. PLRU is unchanged. Invalidating an already-invalid way has no effect.
- Simultaneous events in one cycle:
  - Lookup observes pre-edge state. A same-cycle fill or inval is not visible to it.
  - Fill and inval to the same way: the fill wins, and the way ends valid.
  - Fill and inval to different ways: both apply.
  - Inval of a way that the fill selection would otherwise consider: selection uses pre-edge state.
  - Lookup hit and fill both touch the PLRU: the fill touch is applied last.
- Occupancy is recomputed each cycle as the popcount of next-state valid. It never exceeds NUM_WAYS.

## Timing
- Lookup latency is 1 cycle: resp_* is valid the cycle after lookup_valid, and resp_valid=lookup_valid delayed by one cycle. Back-to-back lookups every cycle are supported.
- Fill write takes effect at the edge that samples fill_valid. A lookup in the next cycle sees the new line.
- evict_* is valid the cycle after the fill.
- valid_vec, dirty_vec and occupancy are registered state and reflect the prior edge.
- Asserting rst mid-operation immediately drops resp_valid and evict_valid to 0 and empties the array. There is no handshake: inputs are single-cycle strobes, and the block never stalls.

## Test plan
- Reset, then lookup tag 0x1: resp_valid=1 one cycle later, resp_hit=0, resp_rdata=0, occupancy=0.
- Fill tags 0x10..0x17 with data=tag replicated and dirty=(tag odd). Expected: ways 0..7 are filled in order, occupancy=8, dirty_vec=8'hAA, evict_valid never asserted.
- Lookup 0x13: resp_hit=1, resp_way=3, resp_dirty=1, resp_rdata=line 0x13 one cycle later. Lookup 0x99: miss.
- After the fills above, touch ways 0..6 by lookup hits, then fill tag 0x20 clean. Expected: victim way 7 (tag 0x17, dirty), evict_valid=1 with evict_tag=0x17 next cycle, lookup 0x17 misses, lookup 0x20 hits way 7.
- Fill an existing tag 0x12 with new data and dirty=1: way 2 is overwritten, dirty_vec bit 2 set, no eviction, occupancy unchanged.
- Same cycle: inval_way=5 with fill 0x30 into a full array. Expected: the fill goes to the PLRU victim, not way 5; valid_vec bit 5 ends 0. Then assert rst mid-lookup: resp_valid=0 and occupancy=0 immediately.
